phi_n_neural_processor: RTL and testbench

- Compact oscillator-bank model of a cortical/hippocampal processor, clocked from a divided update strobe (`clk_4khz_en`).
- Generates phase-accumulator oscillators: theta, Schumann f0, motor beta L5a/L5b and gamma L2/3. Output amplitudes are set by a cognitive-state selector.
- Produces theta–f0 coherence, beta-quiet and Schumann-ignition (SIE) flags, CA3 learn/recall phase signals, and a 12-bit DAC mix.
- Top-level block driving the DAC; the external field inputs come from an SR field generator.

---
 rtl/phi_n_neural_processor.sv | 163 ++++++++++++++++
 tb/tb_phi_n_neural_processor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/phi_n_neural_processor.sv
// phi_n_neural_processor: phase-accumulator oscillator bank with coherence/SIE detection, CA3 phase gating and DAC mix
module phi_n_neural_processor #(
  parameter int WIDTH = 18,
  parameter int FRAC = 14,
  parameter bit FAST_SIM = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic signed [WIDTH-1:0] sensory_input,
  input  logic [2:0] state_select,
  input  logic signed [WIDTH-1:0] sr_field_input,
  input  logic [5*WIDTH-1:0] sr_field_packed,
  output logic [11:0] dac_output,
  output logic signed [WIDTH-1:0] debug_motor_l23,
  output logic signed [WIDTH-1:0] debug_theta,
  output logic ca3_learning,
  output logic ca3_recalling,
  output logic [5:0] ca3_phase_pattern,
  output logic [5:0] cortical_pattern_out,
  output logic signed [WIDTH-1:0] f0_x,
  output logic signed [WIDTH-1:0] f0_y,
  output logic signed [WIDTH-1:0] f0_amplitude,
  output logic signed [WIDTH-1:0] sr_coherence,
  output logic sr_amplification,
  output logic beta_quiet
);
  localparam int DIV = FAST_SIM ? 100 : 31250;
  localparam logic [15:0] ONE = 16'(1 << FRAC);
  logic clk_4khz_en;
  logic [14:0] cnt;
  logic [15:0] theta_ph, f0_ph, l5a_ph, l5b_ph, l23_ph, beta_gain;
  logic [15:0] theta_ph_n, f0_ph_n, l5a_ph_n, l5b_ph_n, l23_ph_n;
  logic [15:0] theta_inc, theta_gain, beta_tgt, beta_n, dph;
  logic signed [15:0] pull;
  logic signed [WIDTH-1:0] motor_l5a_x, motor_l5b_x;
  logic signed [WIDTH-1:0] theta_n, f0_x_n, f0_y_n, l5a_n, l5b_n, l23_n, coh_n, fs, ss;
  logic signed [WIDTH:0] coh_t, coh_d;
  logic signed [20:0] harm, hs;
  logic signed [21:0] mix;
  logic signed [16:0] dac_v;
  logic [11:0] dac_n;
  logic [5:0] pattern_n;
  logic med, wrap, match;
  function automatic logic [15:0] qsin(input logic [4:0] j);
    case (j)
      5'd0: return 16'd0;
      5'd1: return 16'd1606;
      5'd2: return 16'd3196;
      5'd3: return 16'd4756;
      5'd4: return 16'd6270;
      5'd5: return 16'd7723;
      5'd6: return 16'd9102;
      5'd7: return 16'd10394;
      5'd8: return 16'd11585;
      5'd9: return 16'd12665;
      5'd10: return 16'd13623;
      5'd11: return 16'd14449;
      5'd12: return 16'd15137;
      5'd13: return 16'd15679;
      5'd14: return 16'd16069;
      5'd15: return 16'd16305;
      default: return 16'd16384;
    endcase
  endfunction
  function automatic logic signed [15:0] sin_lut(input logic [5:0] i);
    logic [15:0] m;
    m = qsin(i[4] ? 5'd16 - {1'b0, i[3:0]} : {1'b0, i[3:0]});
    return i[5] ? -$signed(m) : $signed(m);
  endfunction
  function automatic logic signed [WIDTH-1:0] scale(input logic [15:0] g, input logic signed [15:0] s);
    logic signed [32:0] p;
    p = $signed({1'b0, g}) * s;
    return WIDTH'(p >>> FRAC);
  endfunction
  function automatic logic signed [WIDTH-1:0] sat(input logic signed [WIDTH:0] v);
    return (v[WIDTH] != v[WIDTH-1]) ? {v[WIDTH], {(WIDTH-1){~v[WIDTH]}}} : v[WIDTH-1:0];
  endfunction
  assign clk_4khz_en = cnt == 15'(DIV - 1);
  assign beta_quiet = beta_gain <= 16'd6144;
  assign sr_amplification = beta_quiet && sr_coherence >= WIDTH'(12288);
  assign f0_amplitude = sr_amplification ? WIDTH'(ONE) : WIDTH'(4096);
  // update divider: free-running counter that wraps on the strobe
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clk_4khz_en ? '0 : cnt + 15'd1;
  // next-update values for every oscillator, detector and the DAC mix
  always_comb begin
    med = state_select == 3'd4;
    theta_gain = state_select == 3'd1 ? 16'd4096 : state_select == 3'd2 ? 16'd12288 : med ? 16'd16384 : 16'd8192;
    beta_tgt = state_select == 3'd1 ? 16'd2048 : state_select == 3'd2 ? 16'd12288 : med ? 16'd4096 : 16'd16384;
    dph = f0_ph - theta_ph;
    pull = $signed(dph) >>> 8;
    theta_inc = med ? 16'd123 + pull : 16'd98;
    theta_ph_n = theta_ph + theta_inc;
    f0_ph_n = f0_ph + 16'd123;
    l5a_ph_n = l5a_ph + 16'd328;
    l5b_ph_n = l5b_ph + 16'd410;
    l23_ph_n = l23_ph + 16'd655;
    wrap = theta_ph[15] & ~theta_ph_n[15] & ~theta_inc[15];
    beta_n = beta_gain < beta_tgt ? (beta_tgt - beta_gain > 16'd16 ? beta_gain + 16'd16 : beta_tgt)
                                  : (beta_gain - beta_tgt > 16'd16 ? beta_gain - 16'd16 : beta_tgt);
    fs = sr_field_input >>> 2;
    ss = sensory_input >>> 2;
    theta_n = scale(theta_gain, sin_lut(theta_ph_n[15:10]));
    f0_x_n = sat((WIDTH+1)'(scale(f0_amplitude[15:0], sin_lut(f0_ph_n[15:10]))) + (WIDTH+1)'(fs));
    f0_y_n = scale(f0_amplitude[15:0], sin_lut(6'(f0_ph_n[15:10] + 6'd16)));
    l5a_n = scale(beta_n, sin_lut(l5a_ph_n[15:10]));
    l5b_n = scale(beta_n, sin_lut(l5b_ph_n[15:10]));
    l23_n = sat((WIDTH+1)'(scale(16'd8192, sin_lut(l23_ph_n[15:10]))) + (WIDTH+1)'(ss));
    match = theta_n[WIDTH-1] == f0_x_n[WIDTH-1];
    coh_t = match ? (WIDTH+1)'(ONE) : '0;
    coh_d = coh_t - (WIDTH+1)'(sr_coherence);
    coh_n = sr_coherence + WIDTH'(coh_d >>> 8);
    pattern_n = {~sensory_input[WIDTH-1], ~l23_n[WIDTH-1], ~l5b_n[WIDTH-1], ~l5a_n[WIDTH-1], ~f0_x_n[WIDTH-1], ~theta_n[WIDTH-1]};
    harm = '0;
    for (int k = 0; k < 5; k++) harm = harm + 21'($signed(sr_field_packed[k*WIDTH +: WIDTH]));
    hs = harm >>> 3;
    mix = 22'(theta_n) + 22'(f0_x_n) + 22'(l5a_n) + 22'(l5b_n) + 22'(l23_n) + 22'(hs);
    dac_v = 17'(mix >>> 5) + 17'sd2048;
    dac_n = dac_v < 17'sd0 ? 12'd0 : dac_v > 17'sd4095 ? 12'd4095 : dac_v[11:0];
  end
  // all model state advances once per update strobe
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      theta_ph <= '0;
      f0_ph <= '0;
      l5a_ph <= '0;
      l5b_ph <= '0;
      l23_ph <= '0;
      beta_gain <= ONE;
      debug_theta <= '0;
      f0_x <= '0;
      f0_y <= '0;
      motor_l5a_x <= '0;
      motor_l5b_x <= '0;
      debug_motor_l23 <= '0;
      sr_coherence <= '0;
      cortical_pattern_out <= '0;
      ca3_phase_pattern <= '0;
      ca3_learning <= 1'b0;
      ca3_recalling <= 1'b0;
      dac_output <= 12'd2048;
    end else if (clk_4khz_en) begin
      theta_ph <= theta_ph_n;
      f0_ph <= f0_ph_n;
      l5a_ph <= l5a_ph_n;
      l5b_ph <= l5b_ph_n;
      l23_ph <= l23_ph_n;
      beta_gain <= beta_n;
      debug_theta <= theta_n;
      f0_x <= f0_x_n;
      f0_y <= f0_y_n;
      motor_l5a_x <= l5a_n;
      motor_l5b_x <= l5b_n;
      debug_motor_l23 <= l23_n;
      sr_coherence <= coh_n;
      cortical_pattern_out <= pattern_n;
      ca3_phase_pattern <= wrap ? cortical_pattern_out : ca3_phase_pattern;
      ca3_learning <= ~theta_ph_n[15];
      ca3_recalling <= theta_ph_n[15];
      dac_output <= dac_n;
    end
endmodule

// File: tb/tb_phi_n_neural_processor.sv
// tb_phi_n_neural_processor: randomized stimulus against a per-update arithmetic model of the oscillator bank
module tb_phi_n_neural_processor;
  localparam real PI = 3.14159265358979;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [17:0] sensory_input, sr_field_input;
  logic [2:0] state_select;
  logic [89:0] sr_field_packed;
  logic [11:0] dac_output;
  logic signed [17:0] debug_motor_l23, debug_theta, f0_x, f0_y, f0_amplitude, sr_coherence;
  logic ca3_learning, ca3_recalling, sr_amplification, beta_quiet;
  logic [5:0] ca3_phase_pattern, cortical_pattern_out;
  int passed = 0;
  int total = 0;
  int lut [64];
  int m_th, m_f0, m_a, m_b, m_g, m_tx, m_fx, m_fy, m_ax, m_bx, m_gx, m_beta, m_c, m_pat, m_ca3, m_learn, m_recall, m_dac;
  int st, sens, fld, u;
  int harm [5];
  phi_n_neural_processor #(.FAST_SIM(1'b1)) dut (
    .clk(clk), .rst(rst), .sensory_input(sensory_input), .state_select(state_select),
    .sr_field_input(sr_field_input), .sr_field_packed(sr_field_packed), .dac_output(dac_output),
    .debug_motor_l23(debug_motor_l23), .debug_theta(debug_theta), .ca3_learning(ca3_learning),
    .ca3_recalling(ca3_recalling), .ca3_phase_pattern(ca3_phase_pattern),
    .cortical_pattern_out(cortical_pattern_out), .f0_x(f0_x), .f0_y(f0_y), .f0_amplitude(f0_amplitude),
    .sr_coherence(sr_coherence), .sr_amplification(sr_amplification), .beta_quiet(beta_quiet)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask
  function automatic int msat(input int v);
    return v > 131071 ? 131071 : v < -131072 ? -131072 : v;
  endfunction
  function automatic int m_amp();
    return (m_beta <= 6144 && m_c >= 12288) ? 16384 : 4096;
  endfunction
  task automatic model_reset();
    {m_th, m_f0, m_a, m_b, m_g, m_tx, m_fx, m_fy, m_ax, m_bx, m_gx, m_c, m_pat, m_ca3, m_learn, m_recall} = '0;
    m_beta = 16384;
    m_dac = 2048;
  endtask
  task automatic model_step();
    int s, tg, tgt, amp, d, inc, old_th, h, sum, v;
    s = st > 4 ? 0 : st;
    tg = s == 1 ? 4096 : s == 2 ? 12288 : s == 4 ? 16384 : 8192;
    tgt = s == 1 ? 2048 : s == 2 ? 12288 : s == 4 ? 4096 : 16384;
    amp = m_amp();
    d = (m_f0 - m_th) & 65535;
    if (d >= 32768) d -= 65536;
    inc = s == 4 ? 123 + (d >>> 8) : 98;
    old_th = m_th;
    m_th = (m_th + inc) & 65535;
    m_f0 = (m_f0 + 123) & 65535;
    m_a = (m_a + 328) & 65535;
    m_b = (m_b + 410) & 65535;
    m_g = (m_g + 655) & 65535;
    if (m_beta < tgt) m_beta = (tgt - m_beta > 16) ? m_beta + 16 : tgt;
    else m_beta = (m_beta - tgt > 16) ? m_beta - 16 : tgt;
    m_tx = (tg * lut[m_th >> 10]) >>> 14;
    m_fx = msat(((amp * lut[m_f0 >> 10]) >>> 14) + (fld >>> 2));
    m_fy = (amp * lut[((m_f0 >> 10) + 16) & 63]) >>> 14;
    m_ax = (m_beta * lut[m_a >> 10]) >>> 14;
    m_bx = (m_beta * lut[m_b >> 10]) >>> 14;
    m_gx = msat(((8192 * lut[m_g >> 10]) >>> 14) + (sens >>> 2));
    m_c = m_c + (((((m_tx < 0) == (m_fx < 0)) ? 16384 : 0) - m_c) >>> 8);
    if (inc >= 0 && old_th >= 32768 && m_th < 32768) m_ca3 = m_pat;
    m_pat = (m_tx >= 0 ? 1 : 0) + (m_fx >= 0 ? 2 : 0) + (m_ax >= 0 ? 4 : 0) + (m_bx >= 0 ? 8 : 0) + (m_gx >= 0 ? 16 : 0) + (sens >= 0 ? 32 : 0);
    m_learn = m_th < 32768 ? 1 : 0;
    m_recall = 1 - m_learn;
    h = 0;
    for (int k = 0; k < 5; k++) h += harm[k];
    sum = m_tx + m_fx + m_ax + m_bx + m_gx + (h >>> 3);
    v = (sum >>> 5) + 2048;
    m_dac = v < 0 ? 0 : v > 4095 ? 4095 : v;
  endtask
  task automatic compare_all();
    check("theta", debug_theta, m_tx);
    check("f0_x", f0_x, m_fx);
    check("f0_y", f0_y, m_fy);
    check("l5a", dut.motor_l5a_x, m_ax);
    check("l5b", dut.motor_l5b_x, m_bx);
    check("l23", debug_motor_l23, m_gx);
    check("coherence", sr_coherence, m_c);
    check("f0_amplitude", f0_amplitude, m_amp());
    check("sr_amplification", int'(sr_amplification), m_amp() == 16384 ? 1 : 0);
    check("beta_quiet", int'(beta_quiet), m_beta <= 6144 ? 1 : 0);
    check("ca3_learning", int'(ca3_learning), m_learn);
    check("ca3_recalling", int'(ca3_recalling), m_recall);
    check("ca3_pattern", int'(ca3_phase_pattern), m_ca3);
    check("cortical_pattern", int'(cortical_pattern_out), m_pat);
    check("dac", int'(dac_output), m_dac);
  endtask
  task automatic drive();
    state_select = 3'(st);
    sensory_input = 18'(sens);
    sr_field_input = 18'(fld);
    for (int k = 0; k < 5; k++) sr_field_packed[k*18 +: 18] = 18'(harm[k]);
  endtask
  task automatic rand_harm();
    for (int k = 0; k < 5; k++) harm[k] = int'($urandom_range(0, 262143)) - 131072;
  endtask
  task automatic sine_field();
    fld = int'($floor(4096.0 * $sin(2.0 * PI * real'(u) * 100.0 / 53400.0) + 0.5));
  endtask
  task automatic tick();
    int n;
    n = 0;
    drive();
    while (dut.clk_4khz_en !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("strobe_timeout", n, 0);
    @(posedge clk);
    model_step();
    u++;
    @(negedge clk);
    compare_all();
  endtask
  initial begin
    #1_500_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 64; i++) begin
      real v;
      v = $sin(2.0 * PI * real'(i) / 64.0) * 16384.0;
      lut[i] = v >= 0.0 ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
    end
    st = 0; sens = 0; fld = 0; u = 0;
    for (int k = 0; k < 5; k++) harm[k] = 0;
    drive();
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    rst = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      check("strobe", int'(dut.clk_4khz_en), (k % 100 == 0) ? 1 : 0);
      @(negedge clk);
      if (k % 100 == 0) begin
        model_step();
        compare_all();
      end
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    compare_all();
    rst = 1'b0;
    st = 0;
    for (int i = 0; i < 40; i++) begin
      sens = int'($urandom_range(0, 262143)) - 131072;
      sine_field();
      rand_harm();
      tick();
    end
    st = 4;
    for (int i = 0; i < 645; i++) begin
      sens = int'($urandom_range(0, 262143)) - 131072;
      sine_field();
      rand_harm();
      tick();
    end
    st = 0;
    for (int i = 0; i < 20; i++) begin
      sens = 8192;
      sine_field();
      tick();
    end
    st = 1; sens = 0; fld = 0;
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 5; k++) harm[k] = i < 10 ? 131071 : -131072;
      tick();
    end
    repeat ($urandom_range(1, 50)) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    model_reset();
    compare_all();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      st = int'($urandom_range(0, 7));
      sens = int'($urandom_range(0, 262143)) - 131072;
      fld = int'($urandom_range(0, 262143)) - 131072;
      rand_harm();
      tick();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
